data_unpack: RTL and testbench

Unpacker on the read side of the accumulator RAM path. It accepts 64-bit words read from the feature-map RAM and emits their four 16-bit neuron values one at a time over a valid/ready stream, so downstream compute consumes one value per handshake. Lane order matches the write-side packer: lane 0 is bits [63:48], lane 3 is bits [15:0].

---
 rtl/data_pack_pkg.sv | 15 +
 rtl/data_unpack.sv | 135 +++++++++++++
 tb/tb_data_unpack.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/data_pack_pkg.sv
// Shared parameters, lane index type and state encoding for the RAM-side unpacker.
package data_pack_pkg;

  localparam int WORD_W = 64;
  localparam int LANE_W = 16;
  localparam int LANES  = WORD_W / LANE_W;

  typedef logic [1:0] lane_t;

  typedef enum logic {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } state_t;

endpackage

// File: rtl/data_unpack.sv
// Splits 64-bit RAM words into four 16-bit lanes on a valid/ready stream, lane 0 = MSBs.
// Optional one-word prefetch slot for bubble-free streaming: DATA_UNPACK_PREFETCH_EN.
module data_unpack
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din_ram,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              flush,
  output logic [LANE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [1:0]        lane_idx,
  output logic              dout_last
);

  state_t              state, state_nxt;
  lane_t               lane, lane_nxt;
  logic [WORD_W-1:0]   word, word_nxt;
  logic                in_hs, out_hs, lane_last;

`ifdef DATA_UNPACK_PREFETCH_EN
  logic [WORD_W-1:0]   pf_word, pf_word_nxt;
  logic                pf_full, pf_full_nxt;
`endif

  assign lane_last = (lane == lane_t'(LANES - 1));

  // din_ready only looks at registered state, flush and rst, never at din_valid
  always_comb begin
    din_ready = 1'b0;
    if (!rst && !flush) begin
      if (state == EMPTY) begin
        din_ready = 1'b1;
      end else begin
`ifdef DATA_UNPACK_PREFETCH_EN
        din_ready = !pf_full;
`else
        din_ready = 1'b0;
`endif
      end
    end
  end

  assign dout_valid = !rst && (state == EMIT);
  assign dout       = rst ? '0 : word[WORD_W-1-LANE_W*int'(lane) -: LANE_W];
  assign lane_idx   = rst ? '0 : lane;
  assign dout_last  = dout_valid && lane_last;

  assign in_hs  = din_valid && din_ready;
  assign out_hs = dout_valid && dout_ready;

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    word_nxt  = word;
`ifdef DATA_UNPACK_PREFETCH_EN
    pf_word_nxt = pf_word;
    pf_full_nxt = pf_full;
`endif
    if (flush) begin
      state_nxt = EMPTY;
      lane_nxt  = '0;
`ifdef DATA_UNPACK_PREFETCH_EN
      pf_full_nxt = 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_hs) begin
            word_nxt  = din_ram;
            lane_nxt  = '0;
            state_nxt = EMIT;
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (lane_last) begin
              lane_nxt = '0;
`ifdef DATA_UNPACK_PREFETCH_EN
              if (pf_full) begin
                word_nxt    = pf_word;
                pf_full_nxt = 1'b0;
              end else if (in_hs) begin
                word_nxt = din_ram;
              end else begin
                state_nxt = EMPTY;
              end
`else
              state_nxt = EMPTY;
`endif
            end else begin
              lane_nxt = lane + lane_t'(1);
            end
          end
`ifdef DATA_UNPACK_PREFETCH_EN
          // an incoming word bypasses the slot when it lands on the lane-3 handshake
          if (in_hs && !(out_hs && lane_last)) begin
            pf_word_nxt = din_ram;
            pf_full_nxt = 1'b1;
          end
`endif
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      lane  <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
      word  <= word_nxt;
    end
  end

`ifdef DATA_UNPACK_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_word <= '0;
      pf_full <= 1'b0;
    end else begin
      pf_word <= pf_word_nxt;
      pf_full <= pf_full_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: directed scenarios then random traffic against a lane-queue model.
module tb_data_unpack;

`ifdef DATA_UNPACK_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, din_valid, din_ready, flush, dout_valid, dout_ready, dout_last;
  logic [63:0] din_ram;
  logic [15:0] dout;
  logic [1:0]  lane_idx;

  always #5 clk = ~clk;

  data_unpack dut (
    .clk(clk), .rst(rst), .din_ram(din_ram), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .lane_idx(lane_idx), .dout_last(dout_last)
  );

  // model: every lane still owed to the consumer, in emission order
  logic [15:0] q[$];
  int checks = 0;
  int passed = 0;
  bit last_ev, last_in, last_out;
  logic [15:0] last_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drive one cycle (inputs set just after posedge), check outputs, advance model at next edge
  task automatic step(input bit v, input logic [63:0] d, input bit rd, input bit fl, input bit r);
    int rem;
    bit ev, edr;
    din_valid = v; din_ram = d; dout_ready = rd; flush = fl; rst = r;
    #1;
    ev  = !r && (q.size() > 0);
    edr = !r && !fl && (PF ? (q.size() <= 4) : (q.size() == 0));
    rem = ev ? ((q.size() - 1) % 4) + 1 : 4;
    chk("din_ready", din_ready, edr);
    chk("dout_valid", dout_valid, ev);
    chk("dout_last", dout_last, ev && rem == 1);
    if (ev) begin
      chk("dout", dout, q[0]);
      chk("lane_idx", lane_idx, 4 - rem);
    end else if (r) begin
      chk("dout_rst", dout, 0);
      chk("lane_idx_rst", lane_idx, 0);
    end
    last_ev = ev; last_in = v && edr; last_out = ev && rd; last_dout = dout;
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      if (last_out) void'(q.pop_front());
      if (last_in) for (int i = 0; i < 4; i++) q.push_back(d[63-16*i -: 16]);
    end
    #1;
  endtask

  initial begin
    logic [63:0] w1, wa, wb, w3;
    logic [15:0] exp1 [4];
    int hs, span, nw;
    bit started;
    w1 = 64'h1111_2222_3333_4444;
    wa = 64'hAAAA_BBBB_CCCC_DDDD;
    wb = 64'h0001_0002_0003_0004;
    w3 = 64'h5A5A_6B6B_7C7C_8D8D;
    exp1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    step(1, w1, 1, 0, 1);
    step(1, w1, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("ready_after_rst", last_in || din_ready, 1'b1);

    // single word, consecutive lanes
    step(1, w1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("t1_lane", last_dout, exp1[i]);
    end

    // back-to-back words
    hs = 0; span = 0; nw = 0; started = 0;
    for (int c = 0; c < 30 && hs < 8; c++) begin
      step(nw < 2, (nw == 0) ? wa : wb, 1, 0, 0);
      if (last_in) nw++;
      if (last_ev) started = 1;
      if (started) span++;
      if (last_out) hs++;
    end
    chk("b2b_count", hs, 8);
    chk("b2b_span", span, PF ? 9 - 1 : 9);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    // stall on lane 1
    step(1, w1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("stall_dout", last_dout, 16'h2222);
      chk("stall_lane", lane_idx, 2'd1);
    end
    step(0, 0, 1, 0, 0);
    chk("stall_resume", last_dout, 16'h2222);
    step(0, 0, 1, 0, 0);
    chk("stall_next", last_dout, 16'h3333);
    step(0, 0, 1, 0, 0);

    // flush on lane 2 with a word offered
    step(1, w1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, wa, 1, 1, 0);
    chk("flush_dropped", q.size(), 0);
    step(1, w3, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("flush_next_lane0", last_dout, 16'h5A5A);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // reset mid-word
    step(1, w1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, wa, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(1, w3, 1, 0, 0);
    chk("rst_accept", last_in, 1'b1);
    step(0, 0, 1, 0, 0);
    chk("rst_next_lane0", last_dout, 16'h5A5A);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 4) != 0,
           ($urandom % 50) == 0, ($urandom % 200) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
